// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Measures the rate of an external pulse / square-wave input by counting its
// rising edges over a fixed gate window of GATE_LEN = F_0/GATE_HZ system clock
// cycles.
//
// Operating modes:
//   * Single shot: a start pulse in IDLE runs exactly one window.
//   * Continuous: while cont is high, windows repeat back-to-back with one
//     DONE cycle between them.
//
// Outputs:
//   * The count of each completed window is latched into result together with
//     an overflow flag.
//   * valid pulses for one cycle when result and ovf update.
//
// Ports:
//   clk     in   1      system clock, all logic on posedge
//   rst     in   1      asynchronous, active-high reset
//   sig_in  in   1      measured signal, asynchronous to clk
//   start   in   1      single-cycle measurement request (sampled in IDLE only)
//   cont    in   1      level; while high, measurements repeat back-to-back
//   busy    out  1      high whenever the FSM is not in IDLE
//   result  out  CNT_W  edge count of the last completed window (held)
//   valid   out  1      one-cycle pulse when result/ovf update
//   ovf     out  1      last completed window saturated (held like result)
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int F_0     = 50_000_000,
    parameter int GATE_HZ = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    output logic             ovf
);

    localparam int GATE_LEN = F_0 / GATE_HZ;
    localparam int GATE_W   = $clog2(GATE_LEN);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_LEN - 1);
    localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Input synchronizer plus one extra flop for edge detection.
    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic edge_s;

    logic [GATE_W-1:0] gate_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_r;
    logic              ovf_flag_r;

    logic              busy_s;
    logic              in_gate_s;
    logic              gate_end_s;
    logic              cnt_en_s;
    logic              sat_s;
    logic [CNT_W-1:0]  edge_cnt_nxt_s;
    logic              ovf_flag_nxt_s;

    // Edge pulse: synchronized level high now, low one cycle earlier.
    assign edge_s = sync2_r & ~sync3_r;

    // Two-flop synchronizer for sig_in followed by the edge-detect delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; start and cont together behave like cont alone.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start || cont) begin
                    state_nxt_s = GATE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GATE: begin
                if (gate_end_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = GATE;
                end
            end
            DONE: begin
                if (cont) begin
                    state_nxt_s = GATE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output decode plus the saturating next-count for the edge counter.
    always_comb begin
        busy_s         = (state_r != IDLE);
        in_gate_s      = (state_r == GATE);
        gate_end_s     = in_gate_s && (gate_cnt_r == GATE_LAST);
        cnt_en_s       = in_gate_s && edge_s;
        sat_s          = (edge_cnt_r == CNT_MAX);
        edge_cnt_nxt_s = edge_cnt_r;
        ovf_flag_nxt_s = ovf_flag_r;
        if (cnt_en_s) begin
            if (sat_s) begin
                // Counter holds at full scale; remember that edges were lost.
                edge_cnt_nxt_s = edge_cnt_r;
                ovf_flag_nxt_s = 1'b1;
            end else begin
                edge_cnt_nxt_s = edge_cnt_r + CNT_ONE;
                ovf_flag_nxt_s = ovf_flag_r;
            end
        end else begin
            edge_cnt_nxt_s = edge_cnt_r;
            ovf_flag_nxt_s = ovf_flag_r;
        end
    end

    assign busy = busy_s;

    // Gate/edge counters run only in GATE; any other state leaves them clear
    // so the next window always starts from zero and IDLE/DONE edges are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_r <= GATE_ZERO;
            edge_cnt_r <= CNT_ZERO;
            ovf_flag_r <= 1'b0;
        end else if (in_gate_s) begin
            gate_cnt_r <= gate_cnt_r + GATE_ONE;
            edge_cnt_r <= edge_cnt_nxt_s;
            ovf_flag_r <= ovf_flag_nxt_s;
        end else begin
            gate_cnt_r <= GATE_ZERO;
            edge_cnt_r <= CNT_ZERO;
            ovf_flag_r <= 1'b0;
        end
    end

    // Result latch: loaded on the last gate cycle (including that cycle's
    // edge) so result/valid are visible during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= CNT_ZERO;
            ovf    <= 1'b0;
        end else begin
            valid <= gate_end_s;
            if (gate_end_s) begin
                result <= edge_cnt_nxt_s;
                ovf    <= ovf_flag_nxt_s;
            end else begin
                result <= result;
                ovf    <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//
// Directed self-checking bench for freq_meter.
//
// Configuration:
//   * F_0=100, GATE_HZ=10, so GATE_LEN=10.
//   * Main instance: CNT_W=8. Second instance: CNT_W=2, used for the
//     saturation cases. Both instances share all inputs.
//
// Timing:
//   * Inputs change 1 time unit after a posedge.
//   * Outputs are sampled 1 time unit after the posedge.
//   * With start driven before edge j0, busy rises after edge j0.
//   * valid is seen after edge j0+GATE_LEN.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    localparam int F_0      = 100;
    localparam int GATE_HZ  = 10;
    localparam int GATE_LEN = 10;

    logic       clk;
    logic       rst;
    logic       sig_in;
    logic       start;
    logic       cont;
    logic       busy;
    logic       valid;
    logic       ovf;
    logic [7:0] result;
    logic       busy_sat;
    logic       valid_sat;
    logic       ovf_sat;
    logic [1:0] result_sat;

    int n_checks = 0;
    int n_pass   = 0;

    freq_meter #(.F_0(F_0), .GATE_HZ(GATE_HZ), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .start  (start),
        .cont   (cont),
        .busy   (busy),
        .result (result),
        .valid  (valid),
        .ovf    (ovf)
    );

    freq_meter #(.F_0(F_0), .GATE_HZ(GATE_HZ), .CNT_W(2)) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .start  (start),
        .cont   (cont),
        .busy   (busy_sat),
        .result (result_sat),
        .valid  (valid_sat),
        .ovf    (ovf_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Square wave: high for the first half of each period; period 0 = constant 1.
    function automatic logic wave(input int period, input int ph, input int j);
        if (period == 0) return 1'b1;
        return (((j + ph) % period) < (period / 2));
    endfunction

    task automatic step(input logic s, input logic st, input logic co);
        sig_in = s;
        start  = st;
        cont   = co;
        @(posedge clk);
        #1;
    endtask

    // One single-shot measurement with start at step j0 = 6.
    task automatic shot(input string tag, input int period, input int ph, input int exp_res,
                        input logic chk_sat, input int exp_sat_res, input logic exp_sat_ovf);
        int         j0     = 6;
        int         nvalid = 0;
        int         nbusy  = 0;
        int         vstep  = -1;
        int         bfirst = -1;
        logic [7:0] res_c  = 8'd0;
        logic       ovf_c  = 1'b0;
        logic [1:0] sres   = 2'd0;
        logic       sovf   = 1'b0;
        logic       svalid = 1'b0;
        for (int j = 0; j <= j0 + GATE_LEN + 4; j++) begin
            step(wave(period, ph, j), (j == j0), 1'b0);
            if (busy) begin
                nbusy++;
                if (bfirst < 0) bfirst = j;
            end
            if (valid) begin
                nvalid++;
                vstep  = j;
                res_c  = result;
                ovf_c  = ovf;
                svalid = valid_sat;
                sres   = result_sat;
                sovf   = ovf_sat;
            end
        end
        check_val({tag, "_busy_first"}, bfirst, j0);
        check_val({tag, "_busy_len"}, nbusy, GATE_LEN + 1);
        check_val({tag, "_valid_cnt"}, nvalid, 1);
        check_val({tag, "_valid_lat"}, vstep, j0 + GATE_LEN);
        check_val({tag, "_result"}, 32'(res_c), exp_res);
        check_val({tag, "_ovf"}, 32'(ovf_c), 0);
        check_val({tag, "_result_hold"}, 32'(result), exp_res);
        if (chk_sat) begin
            check_val({tag, "_sat_valid"}, 32'(svalid), 1);
            check_val({tag, "_sat_result"}, 32'(sres), exp_sat_res);
            check_val({tag, "_sat_ovf"}, 32'(sovf), 32'(exp_sat_ovf));
            check_val({tag, "_sat_idle"}, 32'(busy_sat), 0);
        end
    endtask

    initial begin
        int busy_seen  = 0;
        int valid_seen = 0;
        int nv         = 0;
        int vsteps[8]  = '{default: 0};
        int vres[8]    = '{default: 0};
        int cj0;

        rst    = 1'b1;
        sig_in = 1'b0;
        start  = 1'b0;
        cont   = 1'b0;

        // Reset held 3 cycles with sig_in toggling.
        for (int i = 0; i < 3; i++) begin
            step((i % 2) == 1, 1'b0, 1'b0);
        end
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_valid", 32'(valid), 0);
        check_val("rst_result", 32'(result), 0);
        check_val("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // Idle: input activity without start/cont never triggers anything.
        for (int i = 0; i < 20; i++) begin
            step((i % 2) == 0, 1'b0, 1'b0);
            if (busy)  busy_seen++;
            if (valid) valid_seen++;
        end
        check_val("idle_busy", busy_seen, 0);
        check_val("idle_valid", valid_seen, 0);
        check_val("idle_result", 32'(result), 0);
        check_val("idle_ovf", 32'(ovf), 0);

        // Single shots; expected counts are rising edges entering the
        // synchronizer at steps j0-1 .. j0+8.
        shot("p2", 2, 0, 5, 1'b0, 0, 1'b0);
        shot("const", 0, 0, 0, 1'b0, 0, 1'b0);
        shot("p4_ph0", 4, 0, 2, 1'b0, 0, 1'b0);
        shot("p4_ph3", 4, 3, 3, 1'b0, 0, 1'b0);
        shot("sat_p2", 2, 0, 5, 1'b1, 3, 1'b1);
        shot("sat_p10", 10, 0, 1, 1'b1, 1, 1'b0);

        // Continuous: cont high for 50 steps; dropped mid-window at step 52.
        cj0 = 2;
        for (int j = 0; j <= cj0 + 60; j++) begin
            step(wave(2, 0, j), 1'b0, (j >= cj0) && (j < cj0 + 50));
            if (valid) begin
                if (nv < 8) begin
                    vsteps[nv] = j;
                    vres[nv]   = 32'(result);
                end
                nv++;
            end
        end
        check_val("cont_valid_cnt", nv, 5);
        check_val("cont_first_lat", vsteps[0], cj0 + GATE_LEN);
        for (int m = 0; m < 5; m++) begin
            check_val("cont_result", vres[m], 5);
        end
        for (int m = 1; m < 5; m++) begin
            check_val("cont_spacing", vsteps[m] - vsteps[m-1], GATE_LEN + 1);
        end
        check_val("cont_end_busy", 32'(busy), 0);

        // Reset 4 cycles into a gate window clears outputs asynchronously.
        for (int j = 0; j <= 8; j++) begin
            step(wave(2, 0, j), (j == 4), 1'b0);
        end
        check_val("mid_pre_busy", 32'(busy), 1);
        check_val("mid_pre_result", 32'(result), 5);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_valid", 32'(valid), 0);
        check_val("mid_rst_result", 32'(result), 0);
        check_val("mid_rst_ovf", 32'(ovf), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        shot("post_rst", 2, 0, 5, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
